key_press_scheduler: RTL
========================

# key_press_scheduler

Front-end controller for the game's push-button inputs. Per key, it synchronises the raw asynchronous input through two flops and debounces it. Each debounced press becomes a pending request. A round-robin arbiter delivers pending requests one at a time to the game logic over a valid/ready handshake. It sits between the board KEY pins and the flap/start logic, so game logic never sees raw or bouncing inputs.

## Interface
- N_KEYS, 4, number of key inputs (2..8)
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised cycles needed before the debounced level changes (≥1)
- Clock  input  1  system clock; all state updates on posedge
- Reset_n  input  1  asynchronous, active-low reset
- key_raw  input  N_KEYS  raw asynchronous button levels
- press_ready  input  1  consumer accepts the offered press this cycle
- press_valid  output  1  a press is offered; reset 0
- press_id  output  $clog2(N_KEYS)  index of the offered key; reset 0
- key_level  output  N_KEYS  debounced key levels; reset all 0
- overflow  output  1  one-cycle pulse when a press is merged into an already-pending request; reset 0

## Operation
- Synchroniser: two flops per key, both reset to 0. sync[i] lags key_raw[i] by 2 edges.
- Debounce counter per key, width $clog2(DEBOUNCE_CYCLES+1):
  - If sync[i] == key_level[i], the counter clears.
  - Otherwise it increments.
  - On the DEBOUNCE_CYCLES-th consecutive differing cycle, key_level[i] takes sync[i] and the counter clears.
  - Any glitch back to the old level before then restarts the count.
- Rise detect: the edge on which key_level[i] goes 0→1 sets pending[i]. Falling edges produce nothing.
- Overflow: if pending[i] is already set and is not being transferred on that edge, a rise sets overflow for 1 cycle and the press is merged (dropped).
- Rise on the same edge that key i's pending request is transferred: pending[i] stays 1 (new request), no overflow.
- Arbiter FSM, states IDLE and OFFER:
  - IDLE: if any pending bit is set, load press_id with the round-robin winner, set press_valid, go to OFFER.
  - OFFER: press_valid and press_id are held stable until press_ready.
  - OFFER on transfer (press_valid && press_ready): clear pending[press_id] and update the round-robin pointer to press_id.
  - After the transfer, if another pending bit is set (excluding the one just cleared), load the next winner and stay in OFFER (back-to-back). Otherwise drop press_valid and go to IDLE.
- Round robin: search starts at pointer+1 and wraps at N_KEYS-1→0. The pointer resets to N_KEYS-1, so key 0 wins first after reset.
- Reset mid-operation: pending, counters, synchronisers, FSM, pointer and all outputs clear immediately. Presses in flight are lost.

## Timing
- Raw-to-level latency: key_raw stable from edge 0 gives key_level at edge 2+DEBOUNCE_CYCLES.
- press_valid rises 1 edge after key_level if the FSM is in IDLE.
- Transfer completes on an edge with press_valid && press_ready. Ready may be held high continuously; throughput is 1 press/cycle while requests are pending.
- press_ready while press_valid=0 is ignored.
- press_id never changes while press_valid=1 and press_ready=0.
- All outputs are registered; no combinational path from press_ready to any output.

## Configuration
- KEY_ACTIVE_LOW_EN defined: key_raw is inverted before the first synchroniser flop. This suits the board KEYs, which read 0 when pressed.
- Not defined: key_raw is taken as active-high.
- Reset values and all downstream behaviour are identical in both builds.

## Structure
- Package key_sched_pkg:
  - arbiter state enum (IDLE, OFFER)
  - default constants for N_KEYS and DEBOUNCE_CYCLES
- Sub-module key_debounce:
  - one per key: two-flop synchroniser, debounce counter, key_level register and rise pulse
  - instantiated N_KEYS times via generate
- The top level holds the pending register, the overflow logic, the round-robin pointer and the FSM.

## Test plan
Bench uses DEBOUNCE_CYCLES=4 and N_KEYS=4 unless stated.
- Single press, ready high: key_raw[1] 0→1 at edge 0 → key_level[1]=1 at edge 6; press_valid=1, press_id=1 at edge 7; press_valid=0 at edge 8.
- Bounce rejection: key_raw[2] toggles every 2 cycles for 20 cycles → key_level[2] stays 0, no press_valid. Then hold high → press seen at stable+7.
- Simultaneous presses on keys 0, 2 and 3, ready low 10 cycles then high → press_id=0 held for 10 cycles, then 2, 3 on consecutive cycles. A further press on 0 and 3 afterwards gives the order 0, 3.
- Overflow: key 1 pending with ready low; release then re-press key 1 → overflow pulse for exactly 1 cycle, and only one press with id 1 is delivered.
- Reset_n low for 1 cycle while press_valid=1 → press_valid, press_id, key_level and overflow all go to 0 asynchronously. No press appears until a fresh debounced press.
- With KEY_ACTIVE_LOW_EN defined, key_raw idle at all-ones → no presses. Driving key_raw[0] to 0 → press_id=0 after 7 edges.

Source files
------------

// File: rtl/key_sched_pkg.sv
// Shared types and defaults for the key press scheduler.
// Holds the arbiter state encoding and default sizing constants.
package key_sched_pkg;

    typedef enum logic {
        IDLE,
        OFFER
    } arb_state_e;

    localparam int N_KEYS_DEF   = 4;
    localparam int DEBOUNCE_DEF = 16;

endpackage

// File: rtl/key_debounce.sv
// Per-key two-flop synchroniser, debounce counter and rise detect.
// Ports: Clock, Reset_n, raw (async level), level (debounced), rise (pulse).
module key_debounce
    import key_sched_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          differ;
    logic          done;

    assign differ = (sync2 != level);
    assign done   = differ && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    // Combinational so the pending bit sets on the same edge as level.
    assign rise = done && sync2;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (!differ) begin
            cnt <= '0;
        end else if (done) begin
            cnt   <= '0;
            level <= sync2;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/key_press_scheduler.sv
// Debounced key front end with round-robin press delivery (valid/ready).
// Ports: Clock, Reset_n, key_raw, press_ready -> press_valid, press_id,
// key_level, overflow. Define KEY_ACTIVE_LOW_EN for active-low key_raw.
module key_press_scheduler
    import key_sched_pkg::*;
#(
    parameter int N_KEYS          = N_KEYS_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic                      Clock,
    input  logic                      Reset_n,
    input  logic [N_KEYS-1:0]         key_raw,
    input  logic                      press_ready,
    output logic                      press_valid,
    output logic [$clog2(N_KEYS)-1:0] press_id,
    output logic [N_KEYS-1:0]         key_level,
    output logic                      overflow
);

    localparam int IW = $clog2(N_KEYS);

    logic [N_KEYS-1:0] key_in;
    logic [N_KEYS-1:0] rise;
    logic [N_KEYS-1:0] pending_q;
    logic [N_KEYS-1:0] pending_d;
    logic [N_KEYS-1:0] clr;
    logic [N_KEYS-1:0] sel;
    logic [N_KEYS-1:0] rest;
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     ptr_d;
    logic [IW-1:0]     id_d;
    logic              valid_d;
    logic              ovf_d;
    logic              xfer;
    arb_state_e        state_q;
    arb_state_e        state_d;

`ifdef KEY_ACTIVE_LOW_EN
    assign key_in = ~key_raw;
`else
    assign key_in = key_raw;
`endif

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .Clock  (Clock),
            .Reset_n(Reset_n),
            .raw    (key_in[g]),
            .level  (key_level[g]),
            .rise   (rise[g])
        );
    end

    // First set bit of m searching from p+1 upward, wrapping.
    function automatic logic [IW-1:0] rr_pick(
        input logic [N_KEYS-1:0] m,
        input logic [IW-1:0]     p
    );
        logic [IW-1:0] w;
        int            idx;
        w = '0;
        for (int k = N_KEYS; k >= 1; k--) begin
            idx = (int'(p) + k) % N_KEYS;
            if (m[idx]) w = IW'(idx);
        end
        return w;
    endfunction

    assign xfer = press_valid && press_ready;
    assign sel  = {{(N_KEYS-1){1'b0}}, 1'b1} << press_id;
    assign rest = pending_q & ~sel;

    always_comb begin
        state_d = state_q;
        valid_d = press_valid;
        id_d    = press_id;
        ptr_d   = ptr_q;
        clr     = '0;
        unique case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    id_d    = rr_pick(pending_q, ptr_q);
                    valid_d = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (xfer) begin
                    clr   = sel;
                    ptr_d = press_id;
                    if (|rest) begin
                        id_d = rr_pick(rest, press_id);
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // A rise on a bit being transferred re-arms it rather than merging.
    assign pending_d = (pending_q & ~clr) | rise;
    assign ovf_d     = |(rise & pending_q & ~clr);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            press_valid <= 1'b0;
            press_id    <= '0;
            ptr_q       <= IW'(N_KEYS - 1);
            pending_q   <= '0;
            overflow    <= 1'b0;
        end else begin
            state_q     <= state_d;
            press_valid <= valid_d;
            press_id    <= id_d;
            ptr_q       <= ptr_d;
            pending_q   <= pending_d;
            overflow    <= ovf_d;
        end
    end

endmodule
